// File: rtl/mem2_load_collect_pkg.sv
// Shared CPU definitions: load type bundle, size codes, collector states.
// Imported by the MEM2 load collector and its align/extend helper.
package CPU_Defines;

  typedef struct packed {
    logic       sign;
    logic [1:0] size;
  } load_type_t;

  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } lc_state_t;

endpackage

// File: rtl/mem2_load_collect_load_align.sv
// Combinational align and sign/zero extend of a word-aligned read.
// Ports: rdata (word), off (byte offset), load_type (sign,size) -> data.
import CPU_Defines::*;

module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  load_type_t  load_type,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[{off, 3'b000} +: 8];
    h    = rdata[{off[1], 4'b0000} +: 16];
    data = '0;
    unique case (load_type.size)
      SZ_BYTE: data = {{24{load_type.sign & b[7]}}, b};
      SZ_HALF: data = {{16{load_type.sign & h[15]}}, h};
      SZ_WORD: data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem2_load_collect.sv
// MEM2 load collector: forwards/holds DCache load data, stalls while waiting.
// Ports: MEM2 fields, DCache resp, WB_Wr in; LoadStall/LoadData/LoadDataOk out.
import CPU_Defines::*;

module mem2_load_collect #(
  parameter int DROP_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM2_Flush,
  input  logic        MEM2_Valid,
  input  logic [31:0] MEM2_ALUOut,
  input  load_type_t  MEM2_LoadType,
  input  logic [4:0]  MEM2_ExcType,
  input  logic        DCache_RValid,
  input  logic [31:0] DCache_RData,
  input  logic        WB_Wr,
  output logic        MEM2_LoadStall,
  output logic [31:0] MEM2_LoadData,
  output logic        MEM2_LoadDataOk
);

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  lc_state_t         state;
  logic [DROP_W-1:0] drop_cnt;
  logic [DROP_W-1:0] drop_nxt;
  logic [31:0]       held;
  logic [31:0]       aligned;
  logic              isload;
  logic              acc;
  logic              inc;
  logic              dec;

  load_align u_align (
    .rdata     (DCache_RData),
    .off       (MEM2_ALUOut[1:0]),
    .load_type (MEM2_LoadType),
    .data      (aligned)
  );

  assign isload = MEM2_Valid
                & (MEM2_LoadType.size != SZ_NONE)
                & (MEM2_ExcType == 5'd0)
                & ~MEM2_Flush;

  // Responses owed to killed loads are swallowed first.
  assign acc = DCache_RValid & (drop_cnt == '0);

  // A load leaving WAIT without its data leaves an orphan behind.
  assign inc = (state == ST_WAIT) & ~isload & ~acc;
  assign dec = DCache_RValid & (drop_cnt != '0);

  always_comb begin
    drop_nxt = drop_cnt;
    if (inc && !dec) begin
      if (drop_cnt != DROP_MAX)
        drop_nxt = drop_cnt + 1'b1;
    end else if (dec && !inc) begin
      drop_nxt = drop_cnt - 1'b1;
    end
  end

  always_comb begin
    MEM2_LoadStall  = 1'b0;
    MEM2_LoadDataOk = 1'b0;
    MEM2_LoadData   = '0;
    if (!rst && isload) begin
      if (state == ST_HOLD) begin
        MEM2_LoadDataOk = 1'b1;
        MEM2_LoadData   = held;
      end else if (acc) begin
        MEM2_LoadDataOk = 1'b1;
        MEM2_LoadData   = aligned;
      end else begin
        MEM2_LoadStall  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      drop_cnt <= '0;
      held     <= '0;
    end else begin
      drop_cnt <= drop_nxt;
      unique case (state)
        ST_IDLE: begin
          if (isload) begin
            if (!acc) begin
              state <= ST_WAIT;
            end else if (!WB_Wr) begin
              held  <= aligned;
              state <= ST_HOLD;
            end
          end
        end
        ST_WAIT: begin
          if (!isload) begin
            state <= ST_IDLE;
          end else if (acc) begin
            held  <= aligned;
            state <= WB_Wr ? ST_IDLE : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!isload || WB_Wr)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(inc && !dec && drop_cnt == DROP_MAX))
        else $error("drop_cnt overflow");
  end
`endif

endmodule
